// File: rtl/robin_mon_pkg.sv
// Shared definitions for the monitor front end: opcodes, header layout and parser states.
package robin_mon_pkg;

    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_DUMP = 2'd2;
    localparam logic [1:0] OP_EXEC = 2'd3;

    localparam int unsigned HDR_BYTES = 6;

    localparam logic [2:0] HDR_CMD      = 3'd0;
    localparam logic [2:0] HDR_ADDR_EXT = 3'd1;
    localparam logic [2:0] HDR_ADDR_HI  = 3'd2;
    localparam logic [2:0] HDR_ADDR_LO  = 3'd3;
    localparam logic [2:0] HDR_LEN_HI   = 3'd4;
    localparam logic [2:0] HDR_LEN_LO   = 3'd5;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ECHO   = 2'd1,
        DECODE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    function automatic logic op_valid(input logic [7:0] cmd);
        return (cmd[7:2] == 6'd0) && (cmd[1:0] inside {OP_LOAD, OP_DUMP, OP_EXEC});
    endfunction

endpackage

// File: rtl/mon_frame_timer.sv
// Inter-byte timeout counter: counts while enabled, restarts on clear or on expiry.
module mon_frame_timer #(
    parameter int unsigned LIMIT = 1200000,
    parameter int unsigned WIDTH = 21
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WIDTH-1:0] count_q;

    assign expire = enable && (count_q == WIDTH'(LIMIT - 1));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear || expire) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mon_cmd_parser.sv
// Monitor front end: pops and echoes the 6-byte command header, then offers the
// decoded command to the sequencer. Payload bytes stay in the FIFO.
module mon_cmd_parser
    import robin_mon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned TIMEOUT_CYCLES = 1200000,
    parameter int unsigned TIMEOUT_WIDTH  = 21
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [7:0]            fifo_data,
    output logic                  fifo_read,
    output logic [7:0]            echo_byte,
    output logic                  echo_valid,
    input  logic                  echo_ready,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_op,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [15:0]           cmd_len,
    output logic                  frame_bad,
    output logic                  timeout_err,
    output logic                  busy
);

    state_e state_q, state_d;
    logic [2:0] rc_q, rc_d;
    logic [7:0] hdr_q [HDR_BYTES];

    logic capture;
    logic load_cmd;
    logic bad_d;
    logic tmo_d;
    logic tmr_expire;

    logic                  fifo_read_q;
    logic                  frame_bad_q;
    logic                  timeout_err_q;
    logic [1:0]            cmd_op_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [15:0]           cmd_len_q;

    // Only a partial header waiting on the FIFO can time out; stalls elsewhere never do.
    mon_frame_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timer (
        .CLK    (CLK),
        .reset  (reset),
        .clear  (capture || (rc_q == 3'd0)),
        .enable ((state_q == FETCH) && (rc_q != 3'd0)),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        rc_d     = rc_q;
        capture  = 1'b0;
        load_cmd = 1'b0;
        bad_d    = 1'b0;
        tmo_d    = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (!fifo_empty) begin
                    capture = 1'b1;
                    state_d = ECHO;
                end else if (tmr_expire) begin
                    rc_d  = 3'd0;
                    tmo_d = 1'b1;
                end
            end
            ECHO: begin
                if (echo_ready) begin
                    if (rc_q == HDR_LEN_LO) begin
                        state_d = DECODE;
                    end else begin
                        rc_d    = rc_q + 3'd1;
                        state_d = FETCH;
                    end
                end
            end
            DECODE: begin
                if (op_valid(hdr_q[HDR_CMD])) begin
                    load_cmd = 1'b1;
                    state_d  = HOLD;
                end else begin
                    bad_d   = 1'b1;
                    rc_d    = 3'd0;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (cmd_ready) begin
                    rc_d    = 3'd0;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            rc_q          <= 3'd0;
            fifo_read_q   <= 1'b0;
            frame_bad_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            cmd_op_q      <= 2'd0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= 16'd0;
            for (int i = 0; i < HDR_BYTES; i++) begin
                hdr_q[i] <= 8'd0;
            end
        end else begin
            state_q       <= state_d;
            rc_q          <= rc_d;
            fifo_read_q   <= capture;
            frame_bad_q   <= bad_d;
            timeout_err_q <= tmo_d;
            if (capture) begin
                hdr_q[rc_q] <= fifo_data;
            end
            if (load_cmd) begin
                cmd_op_q   <= hdr_q[HDR_CMD][1:0];
                cmd_addr_q <= ADDR_WIDTH'({hdr_q[HDR_ADDR_HI], hdr_q[HDR_ADDR_LO]});
                cmd_len_q  <= {hdr_q[HDR_LEN_HI], hdr_q[HDR_LEN_LO]};
            end
        end
    end

    assign fifo_read   = fifo_read_q;
    assign echo_valid  = (state_q == ECHO);
    assign echo_byte   = hdr_q[rc_q];
    assign cmd_valid   = (state_q == HOLD);
    assign cmd_op      = cmd_op_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = cmd_len_q;
    assign frame_bad   = frame_bad_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (rc_q != 3'd0) || (state_q != FETCH);

endmodule

// File: tb/tb_mon_cmd_parser.sv
// Self-checking bench for mon_cmd_parser: FIFO/transmit/sequencer models around the DUT,
// directed scenarios followed by randomized frames with random backpressure.
module tb_mon_cmd_parser;

    localparam int AW = 13;

    logic          CLK = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [7:0]    fifo_data;
    logic          fifo_read;
    logic [7:0]    echo_byte;
    logic          echo_valid;
    logic          echo_ready;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_len;
    logic          frame_bad;
    logic          timeout_err;
    logic          busy;

    mon_cmd_parser #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (100),
        .TIMEOUT_WIDTH  (21)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read   (fifo_read),
        .echo_byte   (echo_byte),
        .echo_valid  (echo_valid),
        .echo_ready  (echo_ready),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .frame_bad   (frame_bad),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo_q [$];
    logic [7:0] src_q [$];
    logic [7:0] echo_log [$];
    int gap = 0;
    int max_gap = 0;
    int rand_ready = 0;
    int cyc = 0;
    int pops = 0;
    int n_bad = 0;
    int n_tmo = 0;
    int n_cmd = 0;
    int drop_after_cmd = 0;
    logic [1:0]    got_op;
    logic [AW-1:0] got_addr;
    logic [15:0]   got_len;
    logic       prev_ev = 1'b0;
    logic       prev_er = 1'b0;
    logic [7:0] prev_eb = 8'd0;

    // Expectations for the frame in flight
    logic [47:0] exp_hdr;
    logic        exp_ok;
    int b0, c0, p0, t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    // One clock: observe at the falling edge, update the environment just after the rising edge.
    task automatic tick();
        logic do_pop;
        logic take_cmd;
        @(negedge CLK);
        if (prev_ev && !prev_er) begin
            chk("echo_hold_valid", echo_valid, 1);
            chk("echo_hold_byte", echo_byte, prev_eb);
        end
        if (cmd_valid) chk("no_pop_in_hold", fifo_read, 0);
        if (echo_valid && echo_ready) echo_log.push_back(echo_byte);
        if (frame_bad) n_bad++;
        if (timeout_err) n_tmo++;
        do_pop = fifo_read;
        if (fifo_read) begin
            pops++;
            chk("pop_nonempty", fifo_q.size() != 0, 1);
        end
        take_cmd = cmd_valid && cmd_ready;
        if (take_cmd) begin
            n_cmd++;
            got_op   = cmd_op;
            got_addr = cmd_addr;
            got_len  = cmd_len;
        end
        prev_ev = echo_valid;
        prev_er = echo_ready;
        prev_eb = echo_byte;
        @(posedge CLK);
        #1;
        cyc++;
        if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (take_cmd) begin
            for (int i = 0; i < drop_after_cmd; i++) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                else if (src_q.size() > 0) void'(src_q.pop_front());
            end
        end
        if (gap > 0) begin
            gap--;
        end else if (src_q.size() > 0) begin
            fifo_q.push_back(src_q.pop_front());
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        end
        drive_fifo();
        if (rand_ready != 0) begin
            echo_ready = 1'($urandom_range(0, 1));
            cmd_ready  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic arm(input logic [47:0] h, input int npay);
        exp_hdr = h;
        exp_ok  = (h[47:42] == 6'd0) && (h[41:40] != 2'd0);
        drop_after_cmd = exp_ok ? npay : 0;
        b0 = n_bad;
        c0 = n_cmd;
        p0 = pops;
        t0 = n_tmo;
        echo_log.delete();
    endtask

    task automatic push_frame(input logic [47:0] h, input int npay);
        arm(h, npay);
        for (int i = 0; i < 6; i++) src_q.push_back(h[47-8*i -: 8]);
        for (int i = 0; i < drop_after_cmd; i++) src_q.push_back(8'($urandom));
    endtask

    task automatic wait_frame(input string tag);
        int k = 0;
        logic [31:0] ea;
        while (n_bad == b0 && n_cmd == c0 && k < 3000) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, k < 3000, 1);
        chk({tag, "_echo_n"}, echo_log.size(), 6);
        for (int i = 0; i < 6 && i < echo_log.size(); i++) begin
            chk({tag, "_echo"}, echo_log[i], exp_hdr[47-8*i -: 8]);
        end
        chk({tag, "_pops"}, pops - p0, 6);
        chk({tag, "_no_tmo"}, n_tmo - t0, 0);
        chk({tag, "_drained"}, fifo_q.size() + src_q.size(), 0);
        if (exp_ok) begin
            ea = {16'h0, exp_hdr[31:16]} & ((32'd1 << AW) - 32'd1);
            chk({tag, "_ncmd"}, n_cmd - c0, 1);
            chk({tag, "_nbad"}, n_bad - b0, 0);
            chk({tag, "_op"}, got_op, exp_hdr[41:40]);
            chk({tag, "_addr"}, got_addr, ea);
            chk({tag, "_len"}, got_len, exp_hdr[15:0]);
        end else begin
            chk({tag, "_nbad"}, n_bad - b0, 1);
            chk({tag, "_ncmd"}, n_cmd - c0, 0);
        end
    endtask

    initial begin
        logic [79:0] init_bytes;
        logic [47:0] h;
        logic [7:0]  c;
        int first_rd, first_cv, t3, tt, k;

        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        echo_ready = 1'b1;
        cmd_ready  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_fifo_read", fifo_read, 0);
        chk("rst_echo_valid", echo_valid, 0);
        chk("rst_echo_byte", echo_byte, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_fields", {cmd_op, cmd_addr, cmd_len}, 0);
        chk("rst_pulses", {frame_bad, timeout_err}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (2) tick();

        // 1: whole frame already queued, sequencer not ready yet
        init_bytes = 80'h01_00_00_10_00_04_A1_A2_A3_A4;
        arm(init_bytes[79:32], 4);
        for (int i = 0; i < 10; i++) fifo_q.push_back(init_bytes[79-8*i -: 8]);
        drive_fifo();
        first_rd = -1;
        first_cv = -1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (fifo_read && first_rd < 0) first_rd = i;
            if (cmd_valid && first_cv < 0) first_cv = i;
        end
        chk("t1_first_pop_cycle", first_rd, 1);
        chk("t1_cmd_valid_cycle", first_cv, 13);
        chk("t1_pops_while_held", pops - p0, 6);
        chk("t1_payload_left", fifo_q.size(), 4);
        chk("t1_hold_op", cmd_op, 1);
        chk("t1_hold_addr", cmd_addr, 13'h0010);
        chk("t1_hold_len", cmd_len, 16'd4);
        cmd_ready = 1'b1;
        wait_frame("t1");

        // 2: address truncation, addr_ext ignored
        push_frame(48'h02_FF_3F_FF_00_01, 2);
        wait_frame("t2");

        // 3: invalid opcode discarded, then a good frame
        push_frame(48'h00_00_00_00_00_00, 0);
        wait_frame("t3_bad");
        push_frame(48'h03_00_00_00_12_34, 0);
        wait_frame("t3_good");

        // 4: long echo backpressure on the first byte
        echo_ready = 1'b0;
        push_frame(48'h01_05_01_23_00_10, 1);
        repeat (100) tick();
        chk("t4_single_pop", pops - p0, 1);
        chk("t4_echo_valid", echo_valid, 1);
        chk("t4_echo_byte", echo_byte, 8'h01);
        chk("t4_no_tmo", n_tmo - t0, 0);
        echo_ready = 1'b1;
        wait_frame("t4");

        // 5: partial header times out, next bytes form a fresh frame
        p0 = pops;
        t0 = n_tmo;
        src_q.push_back(8'h02);
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        t3 = -1;
        tt = -1;
        k  = 0;
        while (tt < 0 && k < 400) begin
            tick();
            k++;
            if (pops == p0 + 3 && t3 < 0) t3 = cyc - 1;
            if (n_tmo != t0 && tt < 0) tt = cyc - 1;
        end
        chk("t5_tmo_seen", tt >= 0, 1);
        chk("t5_tmo_delay_in_range", (tt - t3 >= 98) && (tt - t3 <= 104), 1);
        repeat (3) tick();
        chk("t5_tmo_count", n_tmo - t0, 1);
        chk("t5_pops", pops - p0, 3);
        chk("t5_idle", busy, 0);
        push_frame(48'h01_00_02_00_00_00, 0);
        wait_frame("t5_fresh");

        // 6: asynchronous reset while holding a command
        cmd_ready = 1'b0;
        push_frame(48'h03_00_01_23_00_08, 0);
        k = 0;
        while (!cmd_valid && k < 200) begin
            tick();
            k++;
        end
        chk("t6_in_hold", cmd_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_cmd_valid", cmd_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_fields", {cmd_op, cmd_len}, 0);
        repeat (2) @(posedge CLK);
        #1;
        reset   = 1'b0;
        prev_ev = 1'b0;
        cmd_ready = 1'b1;
        push_frame(48'h02_00_00_40_01_00, 0);
        wait_frame("t6_after");

        // Randomized frames with random gaps and backpressure
        rand_ready = 1;
        max_gap    = 3;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 3) == 0) c = 8'($urandom);
            else c = {6'd0, 2'($urandom_range(1, 3))};
            h = {c, 8'($urandom), 32'($urandom)};
            push_frame(h, int'($urandom_range(0, 4)));
            wait_frame("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
